// File: rtl/mmio_slot_interconnect_pkg.sv
// Shared definitions for the MMIO slot interconnect:
// FSM state encoding, default address map and error constants.
package mmio_slot_interconnect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [127:0] DEF_SLOT_BASE = {
        32'h0000_0530, 32'h0000_0520,
        32'h0000_0510, 32'h0000_0500
    };
    localparam logic [31:0] DEF_STAT_BASE  = 32'h0000_05F0;
    localparam logic [31:0] DEF_ERR_DATA   = 32'hDEAD_BEEF;
    localparam logic [31:0] UART_SLOT_BASE = 32'h0000_0500;

    // Error counter saturates instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decoder for the MMIO interconnect.
// Ports: i_addr in; o_slot_hit one-hot, o_slot_idx, o_any_slot,
//   o_stat_hit / o_stat_hi (status pair), o_ram_hit (fallthrough).
module mmio_addr_decode
    import mmio_slot_interconnect_pkg::*;
#(
    parameter int                         WIDTH     = 32,
    parameter int                         NUM_SLOTS = 4,
    parameter int                         SLOT_AW   = 4,
    parameter int                         IDX_W     = 2,
    parameter logic [NUM_SLOTS*WIDTH-1:0] SLOT_BASE = DEF_SLOT_BASE,
    parameter logic [WIDTH-1:0]           STAT_BASE = DEF_STAT_BASE
) (
    input  logic [WIDTH-1:0]     i_addr,
    output logic [NUM_SLOTS-1:0] o_slot_hit,
    output logic [IDX_W-1:0]     o_slot_idx,
    output logic                 o_any_slot,
    output logic                 o_stat_hit,
    output logic                 o_stat_hi,
    output logic                 o_ram_hit
);

    logic [WIDTH-1:0] w_stat_hi_addr;
    logic             w_stat_lo;

    assign w_stat_hi_addr = STAT_BASE + WIDTH'(1);
    assign w_stat_lo      = (i_addr == STAT_BASE);
    assign o_stat_hi      = (i_addr == w_stat_hi_addr);
    assign o_stat_hit     = w_stat_lo | o_stat_hi;

    // Scan from the top so the lowest matching slot is the last writer.
    always_comb begin
        o_slot_hit = '0;
        o_slot_idx = '0;
        o_any_slot = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!o_stat_hit &&
                i_addr[WIDTH-1:SLOT_AW] ==
                SLOT_BASE[i*WIDTH+SLOT_AW +: WIDTH-SLOT_AW]) begin
                o_slot_hit    = '0;
                o_slot_hit[i] = 1'b1;
                o_slot_idx    = IDX_W'(i);
                o_any_slot    = 1'b1;
            end
        end
    end

    assign o_ram_hit = !o_stat_hit && !o_any_slot;

endmodule

// File: rtl/mmio_slot_interconnect.sv
// MMIO decoder between the core data port, data RAM and peripheral slots.
// Ports: CLOCK/RESET (sync, active-low); req_* core side; ram_we/ram_rdata;
//   slot_cs/read/write/addr/wdata out, slot_rdata/slot_ready in; bus_err pulse.
module mmio_slot_interconnect
    import mmio_slot_interconnect_pkg::*;
#(
    parameter int                         WIDTH     = 32,
    parameter int                         NUM_SLOTS = 4,
    parameter int                         SLOT_AW   = 4,
    parameter logic [NUM_SLOTS*WIDTH-1:0] SLOT_BASE = DEF_SLOT_BASE,
    parameter logic [WIDTH-1:0]           STAT_BASE = DEF_STAT_BASE,
    parameter int                         TIMEOUT   = 16,
    parameter logic [WIDTH-1:0]           ERR_DATA  = DEF_ERR_DATA
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic [WIDTH-1:0]           req_addr,
    input  logic [WIDTH-1:0]           req_wdata,
    input  logic                       req_we,
    input  logic                       req_re,
    output logic [WIDTH-1:0]           req_rdata,
    output logic                       req_stall,
    output logic                       bus_err,
    output logic                       ram_we,
    input  logic [WIDTH-1:0]           ram_rdata,
    output logic [NUM_SLOTS-1:0]       slot_cs,
    output logic                       slot_read,
    output logic                       slot_write,
    output logic [SLOT_AW-1:0]         slot_addr,
    output logic [WIDTH-1:0]           slot_wdata,
    input  logic [NUM_SLOTS*WIDTH-1:0] slot_rdata,
    input  logic [NUM_SLOTS-1:0]       slot_ready
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rdata;
    logic [WIDTH-1:0]   r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_we;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_err_addr;
    logic               r_err_sticky;
    logic [7:0]         r_err_cnt;
    logic               r_bus_err;

    logic [NUM_SLOTS-1:0] w_slot_hit;
    logic [IDX_W-1:0]     w_slot_idx;
    logic                 w_any_slot;
    logic                 w_stat_hit;
    logic                 w_stat_hi;
    logic                 w_ram_hit;
    logic                 w_start;
    logic                 w_stat_clr;
    logic                 w_timeout;
    logic                 w_sel_ready;
    logic [WIDTH-1:0]     w_sel_rdata;
    logic [NUM_SLOTS-1:0] w_cs_q;
    logic [WIDTH-1:0]     w_stat_word;
    logic [WIDTH-1:0]     w_stat_rdata;

    mmio_addr_decode #(
        .WIDTH     (WIDTH),
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_AW   (SLOT_AW),
        .IDX_W     (IDX_W),
        .SLOT_BASE (SLOT_BASE),
        .STAT_BASE (STAT_BASE)
    ) u_dec (
        .i_addr     (req_addr),
        .o_slot_hit (w_slot_hit),
        .o_slot_idx (w_slot_idx),
        .o_any_slot (w_any_slot),
        .o_stat_hit (w_stat_hit),
        .o_stat_hi  (w_stat_hi),
        .o_ram_hit  (w_ram_hit)
    );

    assign w_start    = (r_state == ST_IDLE) && w_any_slot
                        && (req_we || req_re);
    assign w_stat_clr = (r_state == ST_IDLE) && w_stat_hit
                        && !w_stat_hi && req_we;
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Only the latched slot's lanes matter during an access.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        w_cs_q      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_ready = slot_ready[i];
                w_sel_rdata = slot_rdata[i*WIDTH +: WIDTH];
                w_cs_q[i]   = 1'b1;
            end
        end
    end

    assign w_stat_word  = {r_err_cnt, {(WIDTH-9){1'b0}}, r_err_sticky};
    assign w_stat_rdata = w_stat_hi ? r_err_addr : w_stat_word;

    assign slot_addr  = r_addr[SLOT_AW-1:0];
    assign slot_wdata = r_wdata;
    assign bus_err    = r_bus_err;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_idx        <= '0;
            r_err_addr   <= '0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_we    <= req_we;
                        r_idx   <= w_slot_idx;
                        r_cnt   <= '0;
                    end else if (w_stat_clr) begin
                        r_err_sticky <= 1'b0;
                        r_err_cnt    <= '0;
                    end
                end
                ST_ACCESS: begin
                    // Ready wins over timeout in the final wait cycle.
                    if (w_sel_ready) begin
                        r_rdata <= w_sel_rdata;
                    end else if (w_timeout) begin
                        r_rdata      <= ERR_DATA;
                        r_bus_err    <= 1'b1;
                        r_err_addr   <= r_addr;
                        r_err_sticky <= 1'b1;
                        r_err_cnt    <= sat_inc(r_err_cnt);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_stall   = 1'b0;
        req_rdata   = r_rdata;
        ram_we      = 1'b0;
        slot_cs     = '0;
        slot_read   = 1'b0;
        slot_write  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                req_rdata = w_stat_hit ? w_stat_rdata : ram_rdata;
                ram_we    = req_we && w_ram_hit;
                if (w_start) begin
                    req_stall   = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                req_stall  = 1'b1;
                slot_cs    = w_cs_q;
                slot_read  = !r_we;
                slot_write = r_we;
                if (w_sel_ready || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // slot_cs is a decode of r_idx; w_slot_hit is kept for debug visibility.
    logic w_unused;
    assign w_unused = ^w_slot_hit;

endmodule
